nibble_fifo: RTL and testbench

Synchronous FIFO buffering 4-bit words downstream of the 4-bit D register stage. It accepts one registered nibble per cycle on a write strobe and presents the oldest word first-word-fall-through to the next consumer. Status outputs FULL, EMPTY and COUNT are registered, and sticky error flags catch protocol violations. Depth is parameterised; all state lives in one clock domain.

---
 rtl/fifo_pkg.sv | 12 +
 rtl/nibble_fifo_if.sv | 32 +++
 rtl/nibble_fifo_mem.sv | 35 +++
 rtl/nibble_fifo.sv | 112 +++++++++++
 tb/tb_nibble_fifo.sv | 182 ++++++++++++++++++
 5 files changed

// File: rtl/fifo_pkg.sv
// Shared constants and helpers for the nibble FIFO slice.
package fifo_pkg;

  localparam int DEFAULT_WIDTH = 4;
  localparam int DEFAULT_DEPTH = 4;

  // Pointer and occupancy width: one extra bit beyond the index holds the wrap bit.
  function automatic int PTR_W(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/nibble_fifo_if.sv
// Handshake and status bundle between a nibble producer/consumer and the FIFO.
interface nibble_fifo_if
  import fifo_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int DEPTH = DEFAULT_DEPTH
) ();

  logic                    WR_EN;
  logic [WIDTH-1:0]        WR_DATA;
  logic                    RD_EN;
  logic [WIDTH-1:0]        RD_DATA;
  logic                    FULL;
  logic                    EMPTY;
  logic [PTR_W(DEPTH)-1:0] COUNT;
  logic                    OVERFLOW;
  logic                    UNDERFLOW;
  logic                    CLR_ERR;

  // Producer/consumer side drives requests and watches status.
  modport master (
    output WR_EN, WR_DATA, RD_EN, CLR_ERR,
    input  RD_DATA, FULL, EMPTY, COUNT, OVERFLOW, UNDERFLOW
  );

  // FIFO side accepts requests and reports status.
  modport slave (
    input  WR_EN, WR_DATA, RD_EN, CLR_ERR,
    output RD_DATA, FULL, EMPTY, COUNT, OVERFLOW, UNDERFLOW
  );

endinterface

// File: rtl/nibble_fifo_mem.sv
// DEPTH x WIDTH storage: one synchronous write port, one asynchronous read port, no reset.
module nibble_fifo_mem
  import fifo_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int DEPTH = DEFAULT_DEPTH,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];

  // Next storage contents: only the addressed entry changes on a write.
  always_comb begin
    mem_d = mem_q;
    if (wr_en) begin
      mem_d[wr_addr] = wr_data;
    end
  end

  // Storage is deliberately left unreset; validity is tracked by the pointers.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/nibble_fifo.sv
// First-word-fall-through FIFO for 4-bit words with registered status and sticky error flags.
module nibble_fifo
  import fifo_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int DEPTH = DEFAULT_DEPTH
) (
  input  logic          CLK,
  input  logic          RST,
  nibble_fifo_if.slave  bus
);

  localparam int PW = PTR_W(DEPTH);
  localparam int AW = PW - 1;

  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]    count_q, count_d;
  logic             full_q, full_d;
  logic             empty_q, empty_d;
  logic             overflow_q, overflow_d;
  logic             underflow_q, underflow_d;
  logic             push_ok;
  logic             pop_ok;
  logic [WIDTH-1:0] mem_rdata;

  // Accept decisions come from registered status, so a full FIFO rejects a push even when popping.
  always_comb begin
    push_ok = bus.WR_EN && !full_q;
    pop_ok  = bus.RD_EN && !empty_q;
  end

  // Pointer, occupancy and status next-state; status is derived from the next count so it
  // changes on the same edge as the operation.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) begin
      wr_ptr_d = wr_ptr_q + PW'(1);
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + PW'(1);
      2'b01:   count_d = count_q - PW'(1);
      default: count_d = count_q;
    endcase
    full_d  = (count_d == PW'(DEPTH));
    empty_d = (count_d == '0);
  end

  // Sticky error flags: a fresh violation wins over a clear in the same cycle.
  always_comb begin
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    if (bus.CLR_ERR) begin
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end
    if (bus.WR_EN && full_q) begin
      overflow_d = 1'b1;
    end
    if (bus.RD_EN && empty_q) begin
      underflow_d = 1'b1;
    end
  end

  // Control state register with asynchronous active-low reset.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      full_q      <= 1'b0;
      empty_q     <= 1'b1;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      full_q      <= full_d;
      empty_q     <= empty_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  nibble_fifo_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk     (CLK),
    .wr_en   (push_ok),
    .wr_addr (wr_ptr_q[AW-1:0]),
    .wr_data (bus.WR_DATA),
    .rd_addr (rd_ptr_q[AW-1:0]),
    .rd_data (mem_rdata)
  );

  // Head word is masked while empty so stale storage never leaks out.
  assign bus.RD_DATA   = empty_q ? '0 : mem_rdata;
  assign bus.FULL      = full_q;
  assign bus.EMPTY     = empty_q;
  assign bus.COUNT     = count_q;
  assign bus.OVERFLOW  = overflow_q;
  assign bus.UNDERFLOW = underflow_q;

endmodule

// File: tb/tb_nibble_fifo.sv
// Directed plus randomized checks of nibble_fifo against a queue-based reference model.
module tb_nibble_fifo;

  localparam int WIDTH = 4;
  localparam int DEPTH = 4;

  logic CLK;
  logic RST;

  nibble_fifo_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

  nibble_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  int checks   = 0;
  int failures = 0;

  logic [WIDTH-1:0] model_q [$];
  bit               model_ov;
  bit               model_un;

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // Hard time bound so the run always ends.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkItem(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Compare every visible output with what the queue model predicts.
  task automatic checkOutput(input string tag);
    logic [7:0] exp_head;
    exp_head = (model_q.size() == 0) ? 8'h0 : 8'(model_q[0]);
    checkItem({tag, ".count"},     8'(bus.COUNT),     8'(model_q.size()));
    checkItem({tag, ".full"},      8'(bus.FULL),      8'(model_q.size() == DEPTH));
    checkItem({tag, ".empty"},     8'(bus.EMPTY),     8'(model_q.size() == 0));
    checkItem({tag, ".rd_data"},   8'(bus.RD_DATA),   exp_head);
    checkItem({tag, ".overflow"},  8'(bus.OVERFLOW),  8'(model_ov));
    checkItem({tag, ".underflow"}, 8'(bus.UNDERFLOW), 8'(model_un));
  endtask

  // Drive one cycle of requests, advance the model at the edge, then idle the inputs.
  task automatic applyStimulus(input bit wr, input logic [WIDTH-1:0] data, input bit rd,
                               input bit clr);
    bit was_full;
    bit was_empty;
    bus.WR_EN   = wr;
    bus.WR_DATA = data;
    bus.RD_EN   = rd;
    bus.CLR_ERR = clr;
    @(posedge CLK);
    was_full  = (model_q.size() == DEPTH);
    was_empty = (model_q.size() == 0);
    if (rd && !was_empty) void'(model_q.pop_front());
    if (wr && !was_full) model_q.push_back(data);
    if (clr) begin
      model_ov = 1'b0;
      model_un = 1'b0;
    end
    if (wr && was_full) model_ov = 1'b1;
    if (rd && was_empty) model_un = 1'b1;
    #1;
    bus.WR_EN   = 1'b0;
    bus.RD_EN   = 1'b0;
    bus.CLR_ERR = 1'b0;
  endtask

  initial begin
    RST         = 1'b0;
    bus.WR_EN   = 1'b0;
    bus.WR_DATA = '0;
    bus.RD_EN   = 1'b0;
    bus.CLR_ERR = 1'b0;
    model_ov    = 1'b0;
    model_un    = 1'b0;

    #12;
    checkOutput("reset");
    RST = 1'b1;
    @(posedge CLK);
    #1;

    // Fill with 1..4; head shows 1 from the first edge.
    for (int i = 1; i <= 4; i++) begin
      applyStimulus(1'b1, 4'(i), 1'b0, 1'b0);
      checkOutput($sformatf("fill%0d", i));
    end

    // Push while full is rejected and flagged.
    applyStimulus(1'b1, 4'h5, 1'b0, 1'b0);
    checkOutput("overflow");

    // Drain 1..4, then one extra pop underflows.
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, 4'h0, 1'b1, 1'b0);
      checkOutput($sformatf("drain%0d", i));
    end
    applyStimulus(1'b0, 4'h0, 1'b1, 1'b0);
    checkOutput("underflow");
    applyStimulus(1'b0, 4'h0, 1'b0, 1'b1);
    checkOutput("clr_err");

    // Simultaneous push+pop at count 2.
    applyStimulus(1'b1, 4'h8, 1'b0, 1'b0);
    applyStimulus(1'b1, 4'h9, 1'b0, 1'b0);
    applyStimulus(1'b1, 4'hA, 1'b1, 1'b0);
    checkOutput("pushpop_mid");
    applyStimulus(1'b0, 4'h0, 1'b1, 1'b0);
    applyStimulus(1'b0, 4'h0, 1'b1, 1'b0);
    checkOutput("pushpop_mid_drain");

    // Simultaneous push+pop when empty.
    applyStimulus(1'b1, 4'h7, 1'b1, 1'b0);
    checkOutput("pushpop_empty");
    applyStimulus(1'b0, 4'h0, 1'b1, 1'b1);
    checkOutput("pushpop_empty_drain");

    // Simultaneous push+pop when full.
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 4'(i + 2), 1'b0, 1'b0);
    applyStimulus(1'b1, 4'hF, 1'b1, 1'b0);
    checkOutput("pushpop_full");
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 4'h0, 1'b1, 1'b0);
    applyStimulus(1'b0, 4'h0, 1'b0, 1'b1);
    checkOutput("pushpop_full_drain");

    // Wrap-around across the DEPTH boundary.
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 4'h3, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 4'h0, 1'b1, 1'b0);
    applyStimulus(1'b1, 4'hC, 1'b0, 1'b0);
    applyStimulus(1'b1, 4'hD, 1'b0, 1'b0);
    applyStimulus(1'b1, 4'hE, 1'b0, 1'b0);
    checkOutput("wrap_filled");
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 4'h0, 1'b1, 1'b0);
      checkOutput($sformatf("wrap_pop%0d", i));
    end

    // Randomized traffic, clears kept rare so flags stay observable.
    for (int i = 0; i < 300; i++) begin
      applyStimulus(1'($urandom_range(0, 1)), 4'($urandom), 1'($urandom_range(0, 1)),
                    ($urandom_range(0, 15) == 0));
      checkOutput($sformatf("rand%0d", i));
    end

    // Asynchronous reset mid-stream at count 3, between clock edges.
    applyStimulus(1'b0, 4'h0, 1'b0, 1'b1);
    while (model_q.size() > 0) applyStimulus(1'b0, 4'h0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 4'(i + 4), 1'b0, 1'b0);
    checkOutput("pre_async_rst");
    #3;
    RST = 1'b0;
    #1;
    model_q.delete();
    model_ov = 1'b0;
    model_un = 1'b0;
    checkOutput("async_rst");
    #2;
    RST = 1'b1;
    applyStimulus(1'b1, 4'hB, 1'b0, 1'b0);
    checkOutput("post_rst_push");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
